// File: rtl/uart_apb_ctrl.sv
// uart_apb_ctrl - APB3 register front end for the UART datapath.
//
// Turns APB register accesses into single-cycle TX FIFO pushes and RX FIFO
// pops, holds the baud divisor and interrupt enables, and collects status,
// sticky error flags and one level interrupt.
//
// Ports:
//   clk, rst_n                 system clock, asynchronous active-low reset
//   psel/penable/pwrite        APB control
//   paddr[4:0]                 byte address, [4:2] selects the register
//   pwdata/prdata[31:0]        APB write / read data (prdata is 0 unless pready)
//   pready, pslverr            APB completion and error response
//   tx_wr_en, tx_din           TX FIFO push strobe and data
//   tx_full, tx_empty          TX FIFO flags
//   rx_rd_en, rx_dout          RX FIFO pop strobe and registered read data
//   rx_full, rx_empty          RX FIFO flags
//   rx_ready, rx_error         uart_rx single-cycle event pulses
//   tx_busy, rx_busy           engine activity
//   divisor[31:0]              baud divisor to baud_generate
//   irq                        level interrupt
module uart_apb_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter logic [31:0] DIV_RESET  = 32'd16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [4:0]            paddr,
    input  logic [31:0]           pwdata,
    output logic [31:0]           prdata,
    output logic                  pready,
    output logic                  pslverr,
    output logic                  tx_wr_en,
    output logic [DATA_WIDTH-1:0] tx_din,
    input  logic                  tx_full,
    input  logic                  tx_empty,
    output logic                  rx_rd_en,
    input  logic [DATA_WIDTH-1:0] rx_dout,
    input  logic                  rx_full,
    input  logic                  rx_empty,
    input  logic                  rx_ready,
    input  logic                  rx_error,
    input  logic                  tx_busy,
    input  logic                  rx_busy,
    output logic [31:0]           divisor,
    output logic                  irq
);

    localparam logic [2:0] RegTxData  = 3'd0;
    localparam logic [2:0] RegRxData  = 3'd1;
    localparam logic [2:0] RegStatus  = 3'd2;
    localparam logic [2:0] RegDivisor = 3'd3;
    localparam logic [2:0] RegIrqEn   = 3'd4;

    typedef enum logic [1:0] {StIdle, StPop, StDone} state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [31:0]           div_q, div_d;
    logic [2:0]            irq_en_q, irq_en_d;
    logic                  rx_err_q, rx_err_d;
    logic                  ovr_q, ovr_d;

    logic        access;
    logic [2:0]  reg_sel;
    logic        wr_acc;
    logic        clr_err;
    logic        clr_ovr;
    logic [31:0] status_word;
    logic        unused_paddr;

    // Gating with rst_n drops every strobe the moment reset asserts.
    assign access  = psel & penable & rst_n;
    assign reg_sel = paddr[4:2];
    // Register writes only ever complete in StIdle.
    assign wr_acc  = access & pwrite & (state_q == StIdle);
    assign clr_err = wr_acc & (reg_sel == RegStatus) & pwdata[6];
    assign clr_ovr = wr_acc & (reg_sel == RegStatus) & pwdata[7];

    assign status_word = {24'd0, ovr_q, rx_err_q, rx_busy, tx_busy,
                          rx_full, rx_empty, tx_full, tx_empty};

    assign unused_paddr = ^paddr[1:0];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            rdata_q  <= '0;
            div_q    <= DIV_RESET;
            irq_en_q <= '0;
            rx_err_q <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rdata_q  <= rdata_d;
            div_q    <= div_d;
            irq_en_q <= irq_en_d;
            rx_err_q <= rx_err_d;
            ovr_q    <= ovr_d;
        end
    end

    // Next state: the pop sequence aborts back to idle if the access goes away.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (access && !pwrite && reg_sel == RegRxData && !rx_empty) begin
                    state_d = StPop;
                end
            end
            StPop:   state_d = access ? StDone : StIdle;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Register next values; a new sticky event beats a same-cycle clear.
    always_comb begin
        rdata_d  = rdata_q;
        div_d    = div_q;
        irq_en_d = irq_en_q;
        if (state_q == StPop) begin
            rdata_d = rx_dout;
        end
        if (wr_acc && reg_sel == RegDivisor) begin
            div_d = pwdata;
        end
        if (wr_acc && reg_sel == RegIrqEn) begin
            irq_en_d = pwdata[2:0];
        end
        rx_err_d = rx_error | (rx_err_q & ~clr_err);
        ovr_d    = (rx_ready & rx_full) | (ovr_q & ~clr_ovr);
    end

    // APB response and FIFO strobes
    always_comb begin
        prdata   = '0;
        pready   = 1'b0;
        pslverr  = 1'b0;
        tx_wr_en = 1'b0;
        tx_din   = '0;
        rx_rd_en = 1'b0;
        if (access) begin
            unique case (state_q)
                StIdle: begin
                    pready = 1'b1;
                    unique case (reg_sel)
                        RegTxData: begin
                            if (pwrite) begin
                                if (tx_full) begin
                                    pslverr = 1'b1;
                                end else begin
                                    tx_wr_en = 1'b1;
                                    tx_din   = pwdata[DATA_WIDTH-1:0];
                                end
                            end
                        end
                        RegRxData: begin
                            if (!pwrite) begin
                                if (rx_empty) begin
                                    pslverr = 1'b1;
                                end else begin
                                    pready   = 1'b0;
                                    rx_rd_en = 1'b1;
                                end
                            end
                        end
                        RegStatus: begin
                            if (!pwrite) prdata = status_word;
                        end
                        RegDivisor: begin
                            if (!pwrite) prdata = div_q;
                        end
                        RegIrqEn: begin
                            if (!pwrite) prdata = {29'd0, irq_en_q};
                        end
                        default: pslverr = 1'b1;
                    endcase
                end
                StPop: pready = 1'b0;
                StDone: begin
                    pready = 1'b1;
                    prdata = 32'(rdata_q);
                end
                default: pready = 1'b0;
            endcase
        end
    end

    assign divisor = div_q;
    assign irq     = |(irq_en_q & {rx_err_q | ovr_q, tx_empty, ~rx_empty});

endmodule

// File: tb/tb_uart_apb_ctrl.sv
// Bench for uart_apb_ctrl: behavioural TX/RX FIFOs with a loopback path, a
// transaction-level reference model, directed pins and randomized traffic.
module tb_uart_apb_ctrl;

    localparam int TxDepth = 4;
    localparam int RxDepth = 4;
    localparam int LoopPer = 5;

    logic        clk, rst_n;
    logic        psel, penable, pwrite;
    logic [4:0]  paddr;
    logic [31:0] pwdata, prdata;
    logic        pready, pslverr;
    logic        tx_wr_en;
    logic [7:0]  tx_din;
    logic        tx_full, tx_empty;
    logic        rx_rd_en;
    logic [7:0]  rx_dout;
    logic        rx_full, rx_empty;
    logic        rx_ready, rx_error;
    logic        tx_busy, rx_busy;
    logic [31:0] divisor;
    logic        irq;

    uart_apb_ctrl #(.DATA_WIDTH(8), .DIV_RESET(32'd16)) dut (
        .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
        .pslverr(pslverr), .tx_wr_en(tx_wr_en), .tx_din(tx_din), .tx_full(tx_full),
        .tx_empty(tx_empty), .rx_rd_en(rx_rd_en), .rx_dout(rx_dout), .rx_full(rx_full),
        .rx_empty(rx_empty), .rx_ready(rx_ready), .rx_error(rx_error), .tx_busy(tx_busy),
        .rx_busy(rx_busy), .divisor(divisor), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- environment: FIFOs and loopback ----------------
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    bit loop_en = 0, err_rand = 0, busy_rand = 0, err_req = 0;

    initial begin
        logic s_wr, s_rd;
        logic [7:0] s_din, pend_b;
        bit pend_v, pend_drop;
        int lp_cnt;
        pend_v = 0; pend_drop = 0; pend_b = 0; lp_cnt = 0;
        rx_dout = 0; rx_ready = 0; rx_error = 0; tx_busy = 0; rx_busy = 0;
        tx_full = 0; tx_empty = 1; rx_full = 0; rx_empty = 1;
        forever begin
            @(negedge clk);
            s_wr = tx_wr_en; s_din = tx_din; s_rd = rx_rd_en;
            @(posedge clk);
            #2;
            if (s_rd === 1'b1 && rx_q.size() > 0) rx_dout = rx_q.pop_front();
            if (pend_v) begin
                if (!pend_drop) rx_q.push_back(pend_b);
                pend_v = 0;
            end
            if (s_wr === 1'b1 && tx_q.size() < TxDepth) tx_q.push_back(s_din);
            rx_ready = 0;
            lp_cnt++;
            if (loop_en && lp_cnt >= LoopPer && tx_q.size() > 0) begin
                lp_cnt    = 0;
                pend_b    = tx_q.pop_front();
                pend_v    = 1;
                pend_drop = (rx_q.size() >= RxDepth);
                rx_ready  = 1;
            end
            rx_error = err_req | (err_rand && $urandom_range(0, 31) == 0);
            tx_busy  = busy_rand ? 1'($urandom) : 1'b0;
            rx_busy  = busy_rand ? 1'($urandom) : 1'b0;
            tx_full  = (tx_q.size() >= TxDepth);
            tx_empty = (tx_q.size() == 0);
            rx_full  = (rx_q.size() >= RxDepth);
            rx_empty = (rx_q.size() == 0);
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] m_div;
    logic [2:0]  m_ien;
    logic        m_err, m_ovr;
    logic [7:0]  m_tx[$];   // bytes accepted for transmission, in order
    logic [7:0]  m_rx[$];   // bytes the RX FIFO must hand back, in order

    wire m_wr     = psel && penable && pwrite;
    wire m_clr6   = m_wr && paddr[4:2] == 3'd2 && pwdata[6];
    wire m_clr7   = m_wr && paddr[4:2] == 3'd2 && pwdata[7];
    wire exp_irq  = |(m_ien & {m_err | m_ovr, tx_empty, !rx_empty});

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_div <= 32'd16;
            m_ien <= 3'd0;
            m_err <= 1'b0;
            m_ovr <= 1'b0;
        end else begin
            if (m_wr && paddr[4:2] == 3'd3) m_div <= pwdata;
            if (m_wr && paddr[4:2] == 3'd4) m_ien <= pwdata[2:0];
            m_err <= rx_error || (m_err && !m_clr6);
            m_ovr <= (rx_ready && rx_full) || (m_ovr && !m_clr7);
        end
    end

    // Received characters: kept unless the RX FIFO is full when they arrive.
    always @(posedge clk) begin
        if (rx_ready === 1'b1 && m_tx.size() > 0) begin
            if (!rx_full) m_rx.push_back(m_tx.pop_front());
            else void'(m_tx.pop_front());
        end
    end

    // ---------------- per-cycle compare ----------------
    bit mon_en = 0;
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            chk("divisor", divisor, m_div);
            chk("irq", irq, exp_irq);
            if (!(psel && penable)) chk("pready_idle", pready, 0);
            if (!psel) chk("strobes_idle", {tx_wr_en, rx_rd_en}, 0);
            if (!pready) chk("pslverr_nready", pslverr, 0);
            if (!pready) chk("prdata_nready", prdata, 0);
        end
    end

    // ---------------- APB transfer with model-derived expectations ----------------
    task automatic xfer(input bit wr, input logic [4:0] addr, input logic [31:0] data,
                        input bit err_acc, output logic [31:0] rd, output bit err,
                        output int waits);
        int wr_cnt, rd_cnt, exp_waits;
        logic [7:0] din;
        logic [31:0] exp_rd;
        bit done, first, pop, exp_err, exp_wr, rx_empty_s;
        wr_cnt = 0; rd_cnt = 0; din = 0; done = 0; first = 1; pop = 0;
        exp_rd = 0; exp_err = 0; exp_wr = 0; rx_empty_s = 0; waits = 0; rd = 0; err = 0;
        psel = 1; penable = 0; pwrite = wr; paddr = addr; pwdata = data;
        @(negedge clk);
        wr_cnt += int'(tx_wr_en); rd_cnt += int'(rx_rd_en);
        @(posedge clk); #1;
        penable = 1; err_req = err_acc;
        for (int c = 0; c < 8 && !done; c++) begin
            @(negedge clk);
            if (first) begin rx_empty_s = rx_empty; first = 0; end
            if (tx_wr_en === 1'b1) din = tx_din;
            wr_cnt += int'(tx_wr_en); rd_cnt += int'(rx_rd_en);
            if (pready === 1'b1) begin
                done = 1; rd = prdata; err = pslverr;
                case (addr[4:2])
                    3'd0: begin exp_err = wr && tx_full; exp_wr = wr && !tx_full; end
                    3'd1: if (!wr) begin exp_err = rx_empty_s; pop = !rx_empty_s; end
                    3'd2: exp_rd = {24'd0, m_ovr, m_err, rx_busy, tx_busy,
                                    rx_full, rx_empty, tx_full, tx_empty};
                    3'd3: exp_rd = m_div;
                    3'd4: exp_rd = {29'd0, m_ien};
                    default: exp_err = 1;
                endcase
                if (pop) exp_rd = (m_rx.size() > 0) ? {24'd0, m_rx.pop_front()} : 32'hDEAD_BEEF;
                if (exp_wr) m_tx.push_back(data[7:0]);
            end else begin
                waits++;
            end
            @(posedge clk); #1;
            err_req = 0;
        end
        psel = 0; penable = 0;
        exp_waits = pop ? 2 : 0;
        chk("xfer_done", done, 1);
        chk("wait_states", waits, exp_waits);
        chk("pslverr", err, exp_err);
        chk("tx_wr_en_pulses", wr_cnt, exp_wr);
        chk("rx_rd_en_pulses", rd_cnt, pop);
        if (exp_wr) chk("tx_din", din, data[7:0]);
        if (!wr) chk("prdata", rd, exp_rd);
    endtask

    task automatic wait_rx(input int n);
        int c;
        c = 0;
        while (rx_q.size() < n && c < 300) begin
            @(posedge clk); #1;
            c++;
        end
        chk("rx_arrival", rx_q.size() >= n, 1);
    endtask

    task automatic pulse_err();
        err_req = 1;
        @(posedge clk); #1;
        err_req = 0;
        @(posedge clk); #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] rd;
        bit err;
        int w;
        logic [7:0] bytes3[3];
        bytes3[0] = 8'h11; bytes3[1] = 8'h22; bytes3[2] = 8'h33;
        rst_n = 0; psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pready", pready, 0);
        chk("rst_pslverr", pslverr, 0);
        chk("rst_prdata", prdata, 0);
        chk("rst_strobes", {tx_wr_en, rx_rd_en}, 0);
        chk("rst_tx_din", tx_din, 0);
        chk("rst_divisor", divisor, 32'h10);
        chk("rst_irq", irq, 0);
        @(posedge clk); #1;
        rst_n = 1; loop_en = 1; mon_en = 1;
        @(posedge clk); #1;

        // Reset values through the bus
        xfer(0, 5'h0C, 0, 0, rd, err, w);
        chk("lit_div_reset", rd, 32'h10);
        chk("lit_div_waits", w, 0);
        xfer(0, 5'h08, 0, 0, rd, err, w);
        chk("lit_status_reset", rd, 32'h05);
        chk("lit_irq_reset", irq, 0);

        // Single byte loopback
        xfer(1, 5'h00, 32'h0000_00A5, 0, rd, err, w);
        chk("lit_tx_a5_err", err, 0);
        wait_rx(1);
        xfer(0, 5'h04, 0, 0, rd, err, w);
        chk("lit_rx_a5", rd, 32'hA5);
        chk("lit_rx_waits", w, 2);
        xfer(0, 5'h08, 0, 0, rd, err, w);
        chk("lit_status_rx_empty", rd[2], 1);

        // Ordered burst, then read past empty
        foreach (bytes3[i]) xfer(1, 5'h00, {24'd0, bytes3[i]}, 0, rd, err, w);
        wait_rx(3);
        foreach (bytes3[i]) begin
            xfer(0, 5'h04, 0, 0, rd, err, w);
            chk("lit_rx_order", rd, {24'd0, bytes3[i]});
        end
        xfer(0, 5'h04, 0, 0, rd, err, w);
        chk("lit_rx_empty_err", err, 1);
        chk("lit_rx_empty_data", rd, 0);

        // Sticky error and interrupt
        xfer(1, 5'h10, 32'h5, 0, rd, err, w);
        pulse_err();
        xfer(0, 5'h08, 0, 0, rd, err, w);
        chk("lit_sticky_set", rd[6], 1);
        chk("lit_irq_set", irq, 1);
        xfer(1, 5'h08, 32'h40, 0, rd, err, w);
        chk("lit_irq_cleared", irq, 0);
        pulse_err();
        xfer(1, 5'h08, 32'h40, 1, rd, err, w);
        xfer(0, 5'h08, 0, 0, rd, err, w);
        chk("lit_set_beats_clear", rd[6], 1);
        xfer(1, 5'h08, 32'hC0, 0, rd, err, w);

        // TX full and unmapped address
        loop_en = 0;
        for (int i = 0; i < TxDepth; i++) xfer(1, 5'h00, 32'h60 + i, 0, rd, err, w);
        xfer(1, 5'h00, 32'h5A, 0, rd, err, w);
        chk("lit_tx_full_err", err, 1);
        xfer(0, 5'h18, 0, 0, rd, err, w);
        chk("lit_unmapped_err", err, 1);
        chk("lit_unmapped_data", rd, 0);
        loop_en = 1;

        // Reset in the middle of an RXDATA pop
        xfer(1, 5'h0C, 32'h1234, 0, rd, err, w);
        wait_rx(4);
        psel = 1; penable = 0; pwrite = 0; paddr = 5'h04;
        @(posedge clk); #1;
        penable = 1;
        @(negedge clk);
        chk("lit_pop_strobe", rx_rd_en, 1);
        @(posedge clk); #1;
        void'(m_rx.pop_front());
        rst_n = 0;
        #1;
        chk("lit_rst_rx_rd_en", rx_rd_en, 0);
        chk("lit_rst_tx_wr_en", tx_wr_en, 0);
        chk("lit_rst_pready", pready, 0);
        chk("lit_rst_pslverr", pslverr, 0);
        chk("lit_rst_divisor", divisor, 32'h10);
        @(negedge clk);
        chk("lit_rst_pready_hold", pready, 0);
        chk("lit_rst_rx_rd_en_hold", rx_rd_en, 0);
        @(posedge clk); #1;
        psel = 0; penable = 0;
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
        xfer(0, 5'h0C, 0, 0, rd, err, w);
        chk("lit_div_after_rst", rd, 32'h10);
        xfer(0, 5'h04, 0, 0, rd, err, w);
        chk("lit_idle_after_rst_waits", w, 2);

        // Randomized traffic
        err_rand = 1; busy_rand = 1;
        for (int t = 0; t < 400; t++) begin
            int r;
            logic [4:0] a;
            logic [31:0] d;
            bit wr;
            r = $urandom_range(0, 9);
            d = $urandom;
            case (r)
                0, 1, 2: begin wr = 1; a = 5'h00; end
                3, 4:    begin wr = 0; a = 5'h04; end
                5:       begin wr = 1'($urandom); a = 5'h08; end
                6:       begin wr = 1'($urandom); a = 5'h0C; end
                7:       begin wr = 1'($urandom); a = 5'h10; end
                8:       begin wr = 1'($urandom); a = {3'($urandom_range(5, 7)), 2'b00}; end
                default: begin wr = 1'($urandom); a = wr ? 5'h04 : 5'h00; end
            endcase
            a[1:0] = 2'($urandom);
            xfer(wr, a, d, 0, rd, err, w);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
